// File: rtl/shift_left_64_pipe.sv
// shift_left_64_pipe: pipelined logical left shifter, out = a << b.
// Matches the latency of the companion right shifter (7 enabled edges) so SHL and SHR
// results write back in order.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears every stage and the output
//   en_i         pipeline advance enable; 0 freezes all stage registers
//   in_valid_i   a_i/b_i carry a real operation this cycle
//   a_i          operand to shift
//   b_i          shift amount, full width; any value >= WIDTH gives 0
//   out_valid_o  out_o holds a completed result
//   out_o        registered result
//
// Structure: stage 0 captures the operand (zeroed if b_i >= WIDTH) and the low shift
// bits; stage k applies a shift of 2^(SHAMT_W-k) when that shift bit is set, largest
// first. The last stage drives the outputs directly.
module shift_left_64_pipe #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_o
);

  // Stage 0..SHAMT_W data and valid; shift amount only needed up to stage SHAMT_W-1.
  logic [WIDTH-1:0]   data_d  [SHAMT_W+1];
  logic [WIDTH-1:0]   data_q  [SHAMT_W+1];
  logic               vld_d   [SHAMT_W+1];
  logic               vld_q   [SHAMT_W+1];
  logic [SHAMT_W-1:0] shamt_d [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];

  logic ovf;

  // Any set bit above the low SHAMT_W bits means the shift amount is >= WIDTH.
  assign ovf = |b_i[WIDTH-1:SHAMT_W];

  assign data_d[0]  = ovf ? '0 : a_i;
  assign vld_d[0]   = in_valid_i;
  assign shamt_d[0] = b_i[SHAMT_W-1:0];

  for (genvar k = 1; k <= SHAMT_W; k++) begin : g_stage
    localparam int unsigned Amt = 2 ** (SHAMT_W - k);

    assign data_d[k] = shamt_q[k-1][SHAMT_W-k] ? (data_q[k-1] << Amt) : data_q[k-1];
    assign vld_d[k]  = vld_q[k-1];

    if (k < SHAMT_W) begin : g_shamt
      assign shamt_d[k] = shamt_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= SHAMT_W; i++) begin
        data_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
      for (int i = 0; i < SHAMT_W; i++) begin
        shamt_q[i] <= '0;
      end
    end else if (en_i) begin
      for (int i = 0; i <= SHAMT_W; i++) begin
        data_q[i] <= data_d[i];
        vld_q[i]  <= vld_d[i];
      end
      for (int i = 0; i < SHAMT_W; i++) begin
        shamt_q[i] <= shamt_d[i];
      end
    end
  end

  assign out_o       = data_q[SHAMT_W];
  assign out_valid_o = vld_q[SHAMT_W];

endmodule

// File: tb/tb_shift_left_64_pipe.sv
// Directed bench for shift_left_64_pipe: reset, latency, boundaries, stall, bubbles,
// plus a random run checked against a 7-entry reference pipeline.
module tb_shift_left_64_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic [63:0] out;

  int total = 0;
  int bad = 0;

  shift_left_64_pipe #(
    .WIDTH  (64),
    .SHAMT_W(6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .in_valid_i (in_valid),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_o      (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_shl(input logic [63:0] av, input logic [63:0] bv);
    if (bv >= 64) return 64'h0;
    return av << bv[5:0];
  endfunction

  logic [63:0] bnd_a [4];
  logic [63:0] bnd_b [4];
  logic [63:0] bnd_e [4];
  logic        mv [7];
  logic [63:0] md [7];

  initial begin
    bnd_a[0] = 64'hFFFFFFFFFFFFFFFF; bnd_b[0] = 64'd0;  bnd_e[0] = 64'hFFFFFFFFFFFFFFFF;
    bnd_a[1] = 64'd1;                bnd_b[1] = 64'd63; bnd_e[1] = 64'h8000000000000000;
    bnd_a[2] = 64'd1;                bnd_b[2] = 64'd64; bnd_e[2] = 64'h0;
    bnd_a[3] = 64'hFFFFFFFFFFFFFFFF; bnd_b[3] = 64'h1000000000000003; bnd_e[3] = 64'h0;

    // Reset state
    tick();
    tick();
    chk("reset_out", out, 64'h0);
    chk("reset_vld", {63'b0, out_valid}, 64'h0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Reset mid-flight: three ops in flight, first one already at the output
    for (int i = 0; i < 3; i++) begin
      a = 64'd5; b = 64'd1; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_pre_vld", {63'b0, out_valid}, 64'h1);
    chk("midrst_pre_out", out, 64'hA);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_async_vld", {63'b0, out_valid}, 64'h0);
    chk("midrst_async_out", out, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("midrst_no_stale", {63'b0, out_valid}, 64'h0);
    end

    // Basic latency
    a = 64'h1111111111111111; b = 64'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lat_before", {63'b0, out_valid}, 64'h0);
    end
    tick();
    chk("lat_vld", {63'b0, out_valid}, 64'h1);
    chk("lat_out", out, 64'h1111111111111110);
    tick();
    chk("lat_after", {63'b0, out_valid}, 64'h0);

    // Boundaries, back-to-back
    for (int i = 0; i < 4; i++) begin
      a = bnd_a[i]; b = bnd_b[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("bnd_before", {63'b0, out_valid}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bnd_vld", {63'b0, out_valid}, 64'h1);
      chk("bnd_out", out, bnd_e[i]);
    end
    tick();
    chk("bnd_after", {63'b0, out_valid}, 64'h0);

    // Stall: issue, one more enabled edge, then 5 disabled edges
    a = 64'hA5; b = 64'd8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // Inputs during the stall must be ignored
      a = 64'hDEAD_0000 + 64'(i); b = 64'd1; in_valid = 1'b1;
      tick();
      chk("stall_vld", {63'b0, out_valid}, 64'h0);
    end
    in_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pre", {63'b0, out_valid}, 64'h0);
    end
    tick();
    chk("stall_res_vld", {63'b0, out_valid}, 64'h1);
    chk("stall_res_out", out, 64'hA500);
    // Freeze during a stall while a valid result sits at the output
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("freeze_vld", {63'b0, out_valid}, 64'h1);
      chk("freeze_out", out, 64'hA500);
    end
    en = 1'b1;
    tick();
    chk("stall_after", {63'b0, out_valid}, 64'h0);
    tick();
    chk("stall_no_ghost", {63'b0, out_valid}, 64'h0);

    // Bubbles: alternate valid, b = i
    for (int j = 0; j < 17; j++) begin
      if (j < 10) begin
        a = 64'h3; b = 64'(j); in_valid = (j % 2 == 0);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (j >= 6) begin
        if ((j - 6) % 2 == 0 && j - 6 < 10) begin
          chk("bub_vld", {63'b0, out_valid}, 64'h1);
          chk("bub_out", out, 64'h3 << (j - 6));
        end else begin
          chk("bub_gap", {63'b0, out_valid}, 64'h0);
        end
      end else begin
        chk("bub_lead", {63'b0, out_valid}, 64'h0);
      end
    end

    // Random with reference pipeline
    for (int k = 0; k < 7; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
    for (int n = 0; n < 10000; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      a        = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) b = 64'($urandom_range(0, 63));
      else b = {$urandom, $urandom};
      tick();
      if (en) begin
        for (int k = 6; k > 0; k--) begin
          mv[k] = mv[k-1];
          md[k] = md[k-1];
        end
        mv[0] = in_valid;
        md[0] = ref_shl(a, b);
      end
      chk("rnd_vld", {63'b0, out_valid}, {63'b0, mv[6]});
      if (mv[6]) chk("rnd_out", out, md[6]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
